mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/arm_pkg.sv | 25 ++
 rtl/mem_timeout_counter.sv | 38 +++
 rtl/mem_access_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared types and constants for the data-memory access path
//
// Purpose : access FSM state encoding, default data-memory base address and
//           the byte-to-word address mapping used by mem_access_ctrl.
// Ports   : none (package).

package arm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam logic [31:0] DEFAULT_ADDR_BASE = 32'd1024;

   // Wraps modulo 2^32 on purpose: addresses below the base are not trapped.
   function automatic logic [31:0] word_addr(input logic [31:0] byte_addr,
                                             input logic [31:0] base);
      logic [31:0] offset;
      offset = byte_addr - base;
      return {2'b00, offset[31:2]};
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - wait-cycle counter for the memory access timeout
//
// Purpose : counts WAIT cycles without acknowledge and flags the last cycle
//           allowed before the access is abandoned.
// Ports   : clk    in  clock, rising edge
//           rst_n  in  asynchronous active-low reset
//           clear  in  restart the count (entry to WAIT)
//           inc    in  one more WAIT cycle passed without ack
//           last   out count has reached TIMEOUT_CYCLES-1

module mem_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic last
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CW'(1);
      end
   end

   assign last = (count == LAST_COUNT);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data memory access controller
//
// Purpose : turns load/store requests from the EXE/MEM register into a
//           request/acknowledge memory transaction, stalling the pipeline
//           until the access completes.
// Config  : MEM_ACCESS_TIMEOUT_EN - abandon an access after TIMEOUT_CYCLES
//           WAIT cycles without ack and pulse mem_err.
// Ports   : clk, rst_n         clock / asynchronous active-low reset
//           mem_r_en, mem_w_en load / store request
//           alu_result         byte address, val_rm store data
//           mem_ack, mem_rdata memory completion strobe and read data
//           mem_req, mem_we    memory request (held until ack), write select
//           mem_addr           word address, mem_wdata write data
//           read_data          load result to WB
//           freeze             pipeline stall, mem_err timeout abort

module mem_access_ctrl
   import arm_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE      = DEFAULT_ADDR_BASE,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] alu_result,
   input  logic [31:0] val_rm,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [31:0] read_data,
   output logic        freeze,
   output logic        mem_err
);

   mem_state_t state;
   logic       access_req;

   assign access_req = mem_r_en | mem_w_en;

   // Combinational so the stall lands in the same cycle the request appears.
   assign freeze = ((state == IDLE) && access_req) || (state == WAIT);

`ifdef MEM_ACCESS_TIMEOUT_EN
   logic tmo_last;
   logic timeout_hit;
   logic mem_err_q;

   mem_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clear ((state == IDLE) && access_req),
      .inc   ((state == WAIT) && !mem_ack),
      .last  (tmo_last)
   );

   // An ack on the final allowed cycle still completes the access normally.
   assign timeout_hit = (state == WAIT) && !mem_ack && tmo_last;
   assign mem_err     = mem_err_q;
`else
   logic [31:0] unused_timeout_cfg;

   // Keeps the timeout parameter referenced when the feature is compiled out.
   assign unused_timeout_cfg = TIMEOUT_CYCLES;
   assign mem_err            = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         read_data <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
         mem_err_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (access_req) begin
                  state     <= WAIT;
                  mem_req   <= 1'b1;
                  // A store wins when both enables are set; the load is dropped.
                  mem_we    <= mem_w_en;
                  mem_addr  <= word_addr(alu_result, ADDR_BASE);
                  mem_wdata <= val_rm;
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  if (!mem_we) begin
                     read_data <= mem_rdata;
                  end
               end
`ifdef MEM_ACCESS_TIMEOUT_EN
               else if (timeout_hit) begin
                  state     <= DONE;
                  mem_req   <= 1'b0;
                  mem_err_q <= 1'b1;
               end
`endif
            end
            DONE: begin
               // One release cycle; the still-held instruction is not reissued.
               state <= IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
               mem_err_q <= 1'b0;
`endif
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl

module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_r_en = 1'b0;
   logic        mem_w_en = 1'b0;
   logic [31:0] alu_result = '0;
   logic [31:0] val_rm = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] read_data;
   logic        freeze;
   logic        mem_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(
      .ADDR_BASE      (32'd1024),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_r_en   (mem_r_en),
      .mem_w_en   (mem_w_en),
      .alu_result (alu_result),
      .val_rm     (val_rm),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .read_data  (read_data),
      .freeze     (freeze),
      .mem_err    (mem_err)
   );

   typedef struct {
      logic        r_en;
      logic        w_en;
      logic [31:0] alu;
      logic [31:0] val;
      logic [31:0] rdata;
      int          ack_wait;
      logic [31:0] exp_addr;
      logic        exp_we;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      int          exp_freeze;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Drives one instruction held through DONE and acks on WAIT cycle ack_wait.
   task automatic run_vec(input string nm, input vec_t v);
      int   fcnt;
      int   waits;
      int   bursts;
      logic prev_req;
      logic done;
      logic acked;
      fcnt = 0; waits = 0; bursts = 0;
      prev_req = 1'b0; done = 1'b0; acked = 1'b0;
      @(posedge clk); #1;
      mem_r_en = v.r_en; mem_w_en = v.w_en;
      alu_result = v.alu; val_rm = v.val;
      mem_ack = 1'b0; mem_rdata = 32'hA5A5A5A5;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (freeze) fcnt++;
         if (mem_req && !prev_req) bursts++;
         prev_req = mem_req;
         if (mem_req) begin
            waits++;
            chk({nm, "_addr"}, mem_addr, v.exp_addr);
            chk1({nm, "_we"}, mem_we, v.exp_we);
            chk({nm, "_wdata"}, mem_wdata, v.exp_wdata);
            mem_ack = (waits == v.ack_wait);
            mem_rdata = mem_ack ? v.rdata : 32'hA5A5A5A5;
            if (mem_ack) acked = 1'b1;
         end else begin
            mem_ack = 1'b0;
            if (acked) begin
               done = 1'b1;
               chk1({nm, "_done_freeze"}, freeze, 1'b0);
               chk({nm, "_read_data"}, read_data, v.exp_rdata);
               chk1({nm, "_mem_err"}, mem_err, 1'b0);
            end
         end
      end
      chk1({nm, "_completed"}, done, 1'b1);
      chki({nm, "_freeze_cycles"}, fcnt, v.exp_freeze);
      chki({nm, "_req_bursts"}, bursts, 1);
      @(posedge clk); #1;
      mem_r_en = 1'b0; mem_w_en = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      chk1({nm, "_after_req"}, mem_req, 1'b0);
      chk1({nm, "_after_freeze"}, freeze, 1'b0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF, 2,
                  32'd2, 1'b0, 32'h0, 32'hDEADBEEF, 3};
      vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hFFFF0000, 1,
                  32'd0, 1'b1, 32'h12345678, 32'hDEADBEEF, 2};
      vecs[2] = '{1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 32'h0BADF00D, 1,
                  32'd1, 1'b1, 32'hCAFEF00D, 32'hDEADBEEF, 2};
      vecs[3] = '{1'b1, 1'b0, 32'd0, 32'h11111111, 32'h01234567, 3,
                  32'h3FFFFF00, 1'b0, 32'h11111111, 32'h01234567, 4};
      vecs[4] = '{1'b1, 1'b0, 32'd1027, 32'h0, 32'h5A5A0001, 1,
                  32'd0, 1'b0, 32'h0, 32'h5A5A0001, 2};
      vecs[5] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h0, 2,
                  32'h3FFFFEFF, 1'b1, 32'h0, 32'h5A5A0001, 3};

      // Reset state
      #12;
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_read_data", read_data, 32'h0);
      chk1("rst_mem_err", mem_err, 1'b0);
      chk1("rst_freeze", freeze, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Stray ack while IDLE with no request
      mem_ack = 1'b1; mem_rdata = 32'h99999999;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("stray_mem_req", mem_req, 1'b0);
         chk1("stray_freeze", freeze, 1'b0);
         chk("stray_read_data", read_data, 32'h0);
      end
      mem_ack = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_vec($sformatf("vec%0d", i), vecs[i]);
      end

      // Reset during the second WAIT cycle
      @(posedge clk); #1;
      mem_r_en = 1'b1; alu_result = 32'd1036; mem_ack = 1'b0;
      @(negedge clk);
      chk1("rstmid_idle_freeze", freeze, 1'b1);
      chk1("rstmid_idle_req", mem_req, 1'b0);
      @(negedge clk);
      chk1("rstmid_wait1_req", mem_req, 1'b1);
      chk("rstmid_wait1_addr", mem_addr, 32'd3);
      @(negedge clk);
      chk1("rstmid_wait2_req", mem_req, 1'b1);
      mem_ack = 1'b1; mem_rdata = 32'h77777777;
      #1 rst_n = 1'b0;
      #1;
      chk1("rstmid_req_drop", mem_req, 1'b0);
      chk("rstmid_addr_clr", mem_addr, 32'h0);
      chk("rstmid_read_data", read_data, 32'h0);
      @(posedge clk); #1;
      mem_r_en = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("rstmid_post_req", mem_req, 1'b0);
         chk1("rstmid_post_freeze", freeze, 1'b0);
         chk("rstmid_post_read_data", read_data, 32'h0);
      end

`ifdef MEM_ACCESS_TIMEOUT_EN
      begin
         vec_t tv;
         int   fcnt;
         int   waits;
         logic done;
         tv = '{1'b1, 1'b0, 32'd1040, 32'h0, 32'h2468ACE0, 4,
                32'd4, 1'b0, 32'h0, 32'h2468ACE0, 5};
         run_vec("tmo_ack_last", tv);

         fcnt = 0; waits = 0; done = 1'b0;
         @(posedge clk); #1;
         mem_r_en = 1'b1; alu_result = 32'd1044; mem_ack = 1'b0;
         for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (freeze) fcnt++;
            if (mem_req) waits++;
            else if (waits > 0) done = 1'b1;
         end
         chk1("tmo_completed", done, 1'b1);
         chki("tmo_wait_cycles", waits, 4);
         chki("tmo_freeze_cycles", fcnt, 5);
         chk1("tmo_mem_err", mem_err, 1'b1);
         chk1("tmo_done_freeze", freeze, 1'b0);
         chk("tmo_read_data", read_data, 32'h2468ACE0);
         chk("tmo_addr", mem_addr, 32'd5);
         @(posedge clk); #1;
         mem_r_en = 1'b0;
         @(negedge clk);
         chk1("tmo_err_pulse_end", mem_err, 1'b0);
         chk1("tmo_after_req", mem_req, 1'b0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
